// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, writeback selects, datapath width.
package execute_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Writeback source select carried down the pipe to the writeback mux.
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU shared by any stage that needs one: result plus zero detect.
module alu
  import execute_stage_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [2:0]   op_i,
  output logic [W-1:0] result_o,
  output logic         zero_o
);

  // Opcode decode; unlisted opcodes produce zero.
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = x_i + y_i;
      ALU_SUB: result_o = x_i - y_i;
      ALU_AND: result_o = x_i & y_i;
      ALU_OR:  result_o = x_i | y_i;
      ALU_SLT: result_o = {{(W-1){1'b0}}, ($signed(x_i) < $signed(y_i))};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch resolution, wrong-path kill window and EX/MEM register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN       = execute_stage_pkg::XLEN,
  parameter int RD_W       = 5,
  parameter int KILL_SLOTS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] imm,
  input  logic [RD_W-1:0] rd,
  input  logic            branch,
  input  logic [1:0]      result_src,
  input  logic            mem_write,
  input  logic            reg_write,
  input  logic            alu_src,
  input  logic [2:0]      alu_control,
  input  logic            stall,
  output logic            zero_flag,
  output logic            branch_flag,
  output logic            flush,
  output logic [XLEN-1:0] alu_result_q,
  output logic [XLEN-1:0] store_data_q,
  output logic [RD_W-1:0] rd_q,
  output logic [1:0]      result_src_q,
  output logic            mem_write_q,
  output logic            reg_write_q
);

  localparam int KW = $clog2(KILL_SLOTS + 1);

  logic [XLEN-1:0] y;
  logic [XLEN-1:0] alu_res;
  logic [KW-1:0]   kill_cnt_q, kill_cnt_d;
  logic            live;

  assign y = alu_src ? imm : b;

  alu #(.W(XLEN)) u_alu (
    .x_i      (a),
    .y_i      (y),
    .op_i     (alu_control),
    .result_o (alu_res),
    .zero_o   (zero_flag)
  );

  // Anything arriving while the kill window is open is wrong-path.
  assign live        = (kill_cnt_q == '0);
  assign branch_flag = branch & live;
  // Held off during stall so the branch re-resolves and fires exactly once.
  assign flush       = branch & live & zero_flag & ~stall;

  // Kill window: open on a taken branch, count down one per advancing slot.
  always_comb begin
    kill_cnt_d = kill_cnt_q;
    if (flush)
      kill_cnt_d = KW'(KILL_SLOTS);
    else if (!live && !stall)
      kill_cnt_d = kill_cnt_q - KW'(1);
  end

  // Kill counter state; reset abandons any open window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) kill_cnt_q <= '0;
    else      kill_cnt_q <= kill_cnt_d;
  end

  // EX/MEM register: holds on stall, squashed slots load with control bits cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      result_src_q <= '0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
    end else if (!stall) begin
      alu_result_q <= alu_res;
      store_data_q <= b;
      rd_q         <= rd;
      result_src_q <= result_src;
      mem_write_q  <= mem_write & live;
      reg_write_q  <= reg_write & live;
    end
  end

endmodule
